// File: rtl/downstream_processor_mc.sv
// downstream_processor_mc: per-channel ack/memwr FSMs with data capture, abort and timeout, round-robin merged onto one valid/ready write port
module downstream_processor_mc #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 15,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ack,
  input  logic [NUM_CH-1:0]        memwr,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic [NUM_CH-1:0]        out,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [CH_W-1:0]          wr_ch,
  output logic [DATA_W-1:0]        wr_data,
  output logic [NUM_CH-1:0]        timeout_err
);
  localparam int TMR_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, PENDING, GRANTED} state_t;
  state_t            st   [NUM_CH];
  logic [TMR_W-1:0]  tmr  [NUM_CH];
  logic [DATA_W-1:0] hold [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   pick;
  logic              found;
  logic              hs;
  logic              load;
  assign hs = wr_valid && wr_ready;
  assign load = !wr_valid || hs;
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && st[(int'(rr_ptr) + k) % NUM_CH] == PENDING) begin
        found = 1'b1;
        pick = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end
  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_CH; i++) out[i] = st[i] != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] <= IDLE;
        tmr[i] <= '0;
        hold[i] <= '0;
      end
      rr_ptr <= '0;
      wr_valid <= 1'b0;
      wr_ch <= '0;
      wr_data <= '0;
      timeout_err <= '0;
    end else begin
      timeout_err <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        case (st[i])
          IDLE: if (ack[i]) begin
            st[i] <= ARMED;
            tmr[i] <= '0;
          end
          ARMED: if (memwr[i]) begin
            st[i] <= PENDING;
            hold[i] <= din[i*DATA_W +: DATA_W];
          end else if (!ack[i]) begin
            st[i] <= IDLE;
          end else if (TIMEOUT != 0 && int'(tmr[i]) + 1 == TIMEOUT) begin
            st[i] <= IDLE;
            timeout_err[i] <= 1'b1;
          end else begin
            tmr[i] <= tmr[i] + TMR_W'(tmr[i] != '1);
          end
          PENDING: if (load && found && pick == CH_W'(i)) st[i] <= GRANTED;
          GRANTED: if (hs && wr_ch == CH_W'(i)) st[i] <= IDLE;
        endcase
      end
      if (hs) rr_ptr <= CH_W'((int'(wr_ch) + 1) % NUM_CH);
      if (load) begin
        wr_valid <= found;
        if (found) begin
          wr_ch <= pick;
          wr_data <= hold[pick];
        end
      end
    end
  end
endmodule

// File: tb/tb_downstream_processor_mc.sv
// tb_downstream_processor_mc: directed scoreboard bench for downstream_processor_mc
module tb_downstream_processor_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ack;
  logic [3:0]  memwr;
  logic [31:0] din;
  logic [3:0]  out;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_data;
  logic [3:0]  timeout_err;
  logic [9:0]  sb [$];
  logic [9:0]  exp_beat;
  int          checks = 0;
  int          errors = 0;
  downstream_processor_mc dut (
    .clk(clk), .rst(rst), .ack(ack), .memwr(memwr), .din(din), .out(out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_data(wr_data),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed beat ch%0d data 'h%0h, expected no beat", wr_ch, wr_data);
      end
      if (sb.size() != 0) begin
        exp_beat = sb.pop_front();
        checks++;
        assert ({wr_ch, wr_data} === exp_beat) else begin
          errors++;
          $error("FAIL sb_beat: observed ch%0d data 'h%0h, expected ch%0d data 'h%0h", wr_ch, wr_data, exp_beat[9:8], exp_beat[7:0]);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, expv);
    end
  endtask
  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    sb.push_back({ch, d});
  endtask
  task automatic arm(input logic [3:0] m);
    ack = m;
    tick();
  endtask
  task automatic wr(input logic [3:0] m, input logic [31:0] d);
    memwr = m;
    din = d;
    ack = 4'b0;
    tick();
    memwr = 4'b0;
  endtask
  initial begin
    rst = 1'b1;
    ack = 4'b0;
    memwr = 4'b0;
    din = '0;
    wr_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_out", out, 0);
    chk("reset_valid", wr_valid, 0);
    chk("reset_err", timeout_err, 0);
    arm(4'b0001);
    chk("legacy_armed_out", out, 4'b0001);
    push(2'd0, 8'hA5);
    wr(4'b0001, 32'h0000_00A5);
    chk("legacy_pending_out", out, 4'b0001);
    chk("legacy_lat1_valid", wr_valid, 0);
    tick();
    chk("legacy_valid", wr_valid, 1);
    chk("legacy_ch", wr_ch, 0);
    chk("legacy_data", wr_data, 8'hA5);
    tick();
    chk("legacy_done_out", out, 0);
    chk("legacy_done_valid", wr_valid, 0);
    wr_ready = 1'b0;
    arm(4'b0010);
    wr(4'b0010, 32'h0000_7700);
    tick();
    chk("rst_stall_valid", wr_valid, 1);
    rst = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_mid_out", out, 0);
    chk("rst_mid_valid", wr_valid, 0);
    chk("rst_mid_ch", wr_ch, 0);
    chk("rst_mid_data", wr_data, 0);
    chk("rst_mid_err", timeout_err, 0);
    wr_ready = 1'b1;
    tick();
    tick();
    chk("rst_no_replay", wr_valid, 0);
    arm(4'hF);
    for (int k = 0; k < 4; k++) push(2'(k), 8'h10 + 8'(k));
    wr(4'hF, 32'h1312_1110);
    chk("rr0_all_busy", out, 4'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr0_valid", wr_valid, 1);
      chk("rr0_ch", wr_ch, k);
    end
    tick();
    chk("rr0_end_valid", wr_valid, 0);
    chk("rr0_end_out", out, 0);
    wr_ready = 1'b0;
    arm(4'b0110);
    push(2'd1, 8'h21);
    push(2'd2, 8'h22);
    wr(4'b0110, 32'h0022_2100);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", wr_valid, 1);
      chk("bp_ch", wr_ch, 1);
      chk("bp_data", wr_data, 8'h21);
      chk("bp_out", out, 4'b0110);
      if (k < 4) tick();
    end
    wr_ready = 1'b1;
    tick();
    chk("bp_next_ch", wr_ch, 2);
    chk("bp_next_data", wr_data, 8'h22);
    chk("bp_next_out", out, 4'b0100);
    tick();
    chk("bp_end_valid", wr_valid, 0);
    arm(4'b0010);
    push(2'd1, 8'h31);
    wr(4'b0010, 32'h0000_3100);
    tick();
    chk("single1_ch", wr_ch, 1);
    tick();
    chk("single1_end", wr_valid, 0);
    arm(4'hF);
    push(2'd2, 8'h42);
    push(2'd3, 8'h43);
    push(2'd0, 8'h40);
    push(2'd1, 8'h41);
    wr(4'hF, 32'h4342_4140);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr2_valid", wr_valid, 1);
      chk("rr2_ch", wr_ch, (k + 2) % 4);
    end
    tick();
    chk("rr2_end_valid", wr_valid, 0);
    arm(4'b1000);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk("to_wait_err", timeout_err, 0);
      chk("to_wait_out", out, 4'b1000);
    end
    tick();
    ack = 4'b0;
    chk("to_err", timeout_err, 4'b1000);
    chk("to_out", out, 0);
    tick();
    chk("to_pulse_once", timeout_err, 0);
    arm(4'b0100);
    ack = 4'b0;
    tick();
    chk("abort_out", out, 0);
    chk("abort_err", timeout_err, 0);
    arm(4'b0001);
    push(2'd0, 8'h55);
    wr(4'b0001, 32'h0000_0055);
    chk("memwr_over_drop", out, 4'b0001);
    tick();
    chk("memwr_over_drop_data", wr_data, 8'h55);
    tick();
    chk("final_valid", wr_valid, 0);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
